// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between the execute stage (port 0) and the
// address/branch-target unit (port 1); one operation in flight, tagged response.
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [4:0]       req0_op,
  input  logic [1:0]       req0_funct,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [4:0]       req1_op,
  input  logic [1:0]       req1_funct,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [4:0]       alu_op,
  output logic [1:0]       alu_funct,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  input  logic             resp_ready,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic             rr_ptr_q;
  logic             grant_id_q;
  logic [4:0]       alu_op_q;
  logic [1:0]       alu_funct_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic             resp_valid_q;
  logic             resp_id_q;
  logic [WIDTH-1:0] resp_data_q;

  logic grant_ok;
  logic gnt;
  logic accept;

  always_comb begin
    // A new grant is allowed when idle, or when the pending response retires this cycle.
    grant_ok  = (state_q == StIdle) || ((state_q == StResp) && resp_ready);
    gnt       = (&req_valid) ? rr_ptr_q : req_valid[1];
    req_ready = 2'b00;
    if (rst_n && grant_ok && (|req_valid)) begin
      req_ready[gnt] = 1'b1;
    end
    accept = |(req_valid & req_ready);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StExec;
      StExec: state_d = StResp;
      StResp: if (resp_ready) state_d = accept ? StExec : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rr_ptr_q     <= 1'b0;
      grant_id_q   <= 1'b0;
      alu_op_q     <= 5'b00000;
      alu_funct_q  <= 2'b00;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_op_q    <= gnt ? req1_op    : req0_op;
        alu_funct_q <= gnt ? req1_funct : req0_funct;
        alu_a_q     <= gnt ? req1_a     : req0_a;
        alu_b_q     <= gnt ? req1_b     : req0_b;
        grant_id_q  <= gnt;
        rr_ptr_q    <= ~gnt;
      end
      if (state_q == StExec) begin
        resp_data_q  <= alu_result;
        resp_id_q    <= grant_id_q;
        resp_valid_q <= 1'b1;
      end else if ((state_q == StResp) && resp_ready) begin
        // Drop valid on every handshake so a back-to-back EXEC never re-presents old data.
        resp_valid_q <= 1'b0;
      end
    end
  end

  assign alu_op     = alu_op_q;
  assign alu_funct  = alu_funct_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter; expected responses queued at issue time and
// checked by an independent monitor on each response handshake.
module tb_alu_share_arbiter;
  localparam int W = 16;
  localparam logic [4:0] OpAlu = 5'b11011;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid, req_ready;
  logic [4:0]    req0_op, req1_op, alu_op;
  logic [1:0]    req0_funct, req1_funct, alu_funct;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result, resp_data;
  logic          resp_valid, resp_id, resp_ready, busy;

  int checks = 0;
  int failures = 0;
  logic [W:0] exp_q[$];
  logic [W:0] mon_e;
  logic [1:0] rdy_tab [7] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};

  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_op(req0_op), .req0_funct(req0_funct), .req0_a(req0_a), .req0_b(req0_b),
    .req1_op(req1_op), .req1_funct(req1_funct), .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_funct(alu_funct), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_data(resp_data), .resp_ready(resp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Small ALU model: funct 00 add, 01 sub, 10 xor, 11 and.
  always_comb begin
    alu_result = '0;
    if (alu_op == OpAlu) begin
      case (alu_funct)
        2'b00: alu_result = alu_a + alu_b;
        2'b01: alu_result = alu_a - alu_b;
        2'b10: alu_result = alu_a ^ alu_b;
        default: alu_result = alu_a & alu_b;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    req0_op = OpAlu; req0_funct = f; req0_a = a; req0_b = b;
  endtask

  task automatic set1(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    req1_op = OpAlu; req1_funct = f; req1_a = a; req1_b = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Monitor: every response handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: got id=%0d data=%0h expected no response",
                 resp_id, resp_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_id", {31'b0, resp_id}, {31'b0, mon_e[W]});
        chk("resp_data", {16'b0, resp_data}, {16'b0, mon_e[W-1:0]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; resp_ready = 1'b1;
    req0_op = '0; req0_funct = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_funct = '0; req1_a = '0; req1_b = '0;
    tick();
    tick();
    // Reset state, with requests present
    req_valid = 2'b11;
    #1;
    chk("rst_req_ready", {30'b0, req_ready}, 0);
    chk("rst_alu_op", {27'b0, alu_op}, 0);
    chk("rst_alu_funct", {30'b0, alu_funct}, 0);
    chk("rst_alu_a", {16'b0, alu_a}, 0);
    chk("rst_alu_b", {16'b0, alu_b}, 0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 0);
    chk("rst_resp_id", {31'b0, resp_id}, 0);
    chk("rst_resp_data", {16'b0, resp_data}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    req_valid = 2'b00;
    rst_n = 1'b1;
    tick();

    // 1: port0 ADD 3+4
    set0(2'b00, 16'h0003, 16'h0004);
    exp_q.push_back({1'b0, 16'h0007});
    req_valid = 2'b01;
    #1 chk("t1_req_ready", {30'b0, req_ready}, 32'h1);
    tick();
    req_valid = 2'b00;
    chk("t1_busy_exec", {31'b0, busy}, 1);
    chk("t1_alu_op", {27'b0, alu_op}, {27'b0, OpAlu});
    chk("t1_alu_a", {16'b0, alu_a}, 32'h3);
    chk("t1_alu_b", {16'b0, alu_b}, 32'h4);
    chk("t1_valid_exec", {31'b0, resp_valid}, 0);
    tick();
    chk("t1_valid_resp", {31'b0, resp_valid}, 1);
    chk("t1_id", {31'b0, resp_id}, 0);
    chk("t1_data", {16'b0, resp_data}, 32'h7);
    tick();
    chk("t1_idle_busy", {31'b0, busy}, 0);
    chk("t1_idle_valid", {31'b0, resp_valid}, 0);

    // 2: both ports continuously valid, grants 0,1,0,1
    do_reset();
    set0(2'b00, 16'h0001, 16'h0002);
    set1(2'b01, 16'h000A, 16'h0003);
    exp_q.push_back({1'b0, 16'h0003});
    exp_q.push_back({1'b1, 16'h0007});
    exp_q.push_back({1'b0, 16'h0003});
    exp_q.push_back({1'b1, 16'h0007});
    req_valid = 2'b11;
    for (int i = 0; i < 7; i++) begin
      #1 chk($sformatf("t2_req_ready_%0d", i), {30'b0, req_ready}, {30'b0, rdy_tab[i]});
      tick();
    end
    req_valid = 2'b00;
    tick();
    tick();
    chk("t2_drained", exp_q.size(), 0);
    chk("t2_idle", {31'b0, busy}, 0);

    // 3: response stalled 5 cycles, then back-to-back grant to waiting port1
    set0(2'b11, 16'hF0F0, 16'h3C3C);
    set1(2'b00, 16'h1000, 16'h0234);
    exp_q.push_back({1'b0, 16'h3030});
    resp_ready = 1'b0;
    req_valid = 2'b01;
    #1 chk("t3_req_ready", {30'b0, req_ready}, 32'h1);
    tick();
    req_valid = 2'b11;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_hold_valid", {31'b0, resp_valid}, 1);
      chk("t3_hold_id", {31'b0, resp_id}, 0);
      chk("t3_hold_data", {16'b0, resp_data}, 32'h3030);
      chk("t3_hold_ready", {30'b0, req_ready}, 0);
      tick();
    end
    resp_ready = 1'b1;
    exp_q.push_back({1'b1, 16'h1234});
    #1 chk("t3_b2b_ready", {30'b0, req_ready}, 32'h2);
    tick();
    req_valid = 2'b00;
    chk("t3_exec_valid", {31'b0, resp_valid}, 0);
    tick();
    chk("t3_id", {31'b0, resp_id}, 1);
    chk("t3_data", {16'b0, resp_data}, 32'h1234);
    tick();

    // 4: port1 only XOR, then simultaneous request goes to port0
    set1(2'b10, 16'h00FF, 16'h0F0F);
    exp_q.push_back({1'b1, 16'h0FF0});
    req_valid = 2'b10;
    #1 chk("t4_req_ready", {30'b0, req_ready}, 32'h2);
    tick();
    req_valid = 2'b00;
    tick();
    chk("t4_id", {31'b0, resp_id}, 1);
    chk("t4_data", {16'b0, resp_data}, 32'h0FF0);
    tick();
    set0(2'b00, 16'h0005, 16'h0006);
    exp_q.push_back({1'b0, 16'h000B});
    req_valid = 2'b11;
    #1 chk("t4_rr_ready", {30'b0, req_ready}, 32'h1);
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    chk("t4_drained", exp_q.size(), 0);

    // 5: reset during EXEC aborts the op
    set0(2'b00, 16'h0100, 16'h0200);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b11;
    chk("t5_busy_exec", {31'b0, busy}, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", {30'b0, req_ready}, 0);
    chk("t5_rst_alu_op", {27'b0, alu_op}, 0);
    chk("t5_rst_alu_a", {16'b0, alu_a}, 0);
    chk("t5_rst_busy", {31'b0, busy}, 0);
    chk("t5_rst_valid", {31'b0, resp_valid}, 0);
    req_valid = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_no_stale_a", {31'b0, resp_valid}, 0);
    tick();
    chk("t5_no_stale_b", {31'b0, resp_valid}, 0);
    set0(2'b00, 16'h0020, 16'h0022);
    set1(2'b01, 16'h0009, 16'h0001);
    exp_q.push_back({1'b0, 16'h0042});
    req_valid = 2'b11;
    #1 chk("t5_first_grant", {30'b0, req_ready}, 32'h1);
    tick();
    req_valid = 2'b00;
    tick();
    tick();

    // 6: port0 pulse during stalled RESP is never granted
    resp_ready = 1'b0;
    set1(2'b00, 16'h0001, 16'h0001);
    exp_q.push_back({1'b1, 16'h0002});
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    tick();
    req_valid = 2'b01;
    #1 chk("t6_pulse_ready", {30'b0, req_ready}, 0);
    tick();
    req_valid = 2'b00;
    tick();
    resp_ready = 1'b1;
    #1;
    chk("t6_ready_after", {30'b0, req_ready}, 0);
    chk("t6_valid", {31'b0, resp_valid}, 1);
    tick();
    tick();
    tick();
    chk("t6_idle", {31'b0, busy}, 0);
    chk("final_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
